// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for pipelined_memory.
//   log2_bytes  - log2 of the bytes-per-word parameter, used to build localparams
//   addr_legal  - alignment plus 33-bit range check, used by both read and write paths
//   rsp_t       - one response pipeline entry (valid, err, data up to MAX_DATA_W bits)
package mem_pkg;

   localparam int unsigned MAX_DATA_W = 64;

   typedef struct packed {
      logic                  valid;
      logic                  err;
      logic [MAX_DATA_W-1:0] data;
   } rsp_t;

   function automatic int unsigned log2_bytes(input int unsigned data_bytes);
      int unsigned r;
      r = 0;
      for (int unsigned b = 1; b < data_bytes; b = b * 2) r = r + 1;
      return r;
   endfunction

   // The limit is formed in 33 bits so an address near 2^32 can never wrap
   // below the end of the array.
   function automatic logic addr_legal(input logic [31:0] addr,
                                       input int unsigned data_bytes,
                                       input int unsigned words);
      logic [31:0] align_mask;
      logic [32:0] limit;
      align_mask = 32'(data_bytes - 1);
      limit      = 33'(words) * 33'(data_bytes);
      return ((addr & align_mask) == 32'd0) && ({1'b0, addr} < limit);
   endfunction

endpackage

// File: rtl/pipelined_memory_if.sv
// pipelined_memory_if: read request/response and write bus of pipelined_memory.
//   master - core side: drives requests, consumes responses
//   slave  - memory side
interface pipelined_memory_if #(
   parameter int unsigned pDataBytes = 4
);
   logic                    iwRdValid;
   logic                    owRdReady;
   logic [31:0]             iwRdAddr;
   logic                    owRspValid;
   logic                    iwRspReady;
   logic [8*pDataBytes-1:0] owRspData;
   logic                    owRspErr;
   logic                    iwWrValid;
   logic [31:0]             iwWrAddr;
   logic [8*pDataBytes-1:0] iwWrData;
   logic [pDataBytes-1:0]   iwWstrb;
   logic                    owWrErr;
   logic [8*pDataBytes-1:0] owLastData;

   modport master (
      output iwRdValid, iwRdAddr, iwRspReady, iwWrValid, iwWrAddr, iwWrData, iwWstrb,
      input  owRdReady, owRspValid, owRspData, owRspErr, owWrErr, owLastData
   );

   modport slave (
      input  iwRdValid, iwRdAddr, iwRspReady, iwWrValid, iwWrAddr, iwWrData, iwWstrb,
      output owRdReady, owRspValid, owRspData, owRspErr, owWrErr, owLastData
   );
endinterface

// File: rtl/mem_rsp_pipe.sv
// mem_rsp_pipe: DEPTH-stage valid/bits register pipeline; every stage holds
// while stall is high. Bits of an empty stage are forced to zero.
//   iwClk, iwnRst      - clock, async active-low reset
//   in_valid, in_bits  - entry captured into stage 0
//   stall              - freeze all stages
//   out_valid, out_bits- last stage
module mem_rsp_pipe #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned W     = 1
) (
   input  logic         iwClk,
   input  logic         iwnRst,
   input  logic         in_valid,
   input  logic [W-1:0] in_bits,
   input  logic         stall,
   output logic         out_valid,
   output logic [W-1:0] out_bits
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [W-1:0]     bits_q [DEPTH];
   logic [W-1:0]     bits_d [DEPTH];

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < DEPTH; i++) bits_d[i] = bits_q[i];
      if (!stall) begin
         valid_d[0] = in_valid;
         bits_d[0]  = in_valid ? in_bits : '0;
         for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            bits_d[i]  = bits_q[i-1];
         end
      end
   end

   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) bits_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) bits_q[i] <= bits_d[i];
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_bits  = bits_q[DEPTH-1];

endmodule

// File: rtl/pipelined_memory.sv
// pipelined_memory: byte-addressed RAM with pipelined read responses
// (valid/ready with backpressure), byte-strobed writes, legality checking
// and a mailbox view of the highest word.
//   iwClk, iwnRst - clock, async active-low reset
//   bus (slave)   - read request/response, write port, owWrErr, owLastData
// Contents are X until written; only the mailbox is cleared by reset.
module pipelined_memory
   import mem_pkg::*;
#(
   parameter int unsigned pWords       = 32'd44,
   parameter int unsigned pDataBytes   = 4,
   parameter int unsigned pReadLatency = 1
) (
   input  logic              iwClk,
   input  logic              iwnRst,
   pipelined_memory_if.slave bus
);

   localparam int unsigned      DW       = 8 * pDataBytes;
   localparam int unsigned      LOG2B    = log2_bytes(pDataBytes);
   localparam int unsigned      IDX_W    = (pWords > 1) ? $clog2(pWords) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pWords - 1);

   // The highest word lives in its own resettable register; the rest of the
   // array has no reset so its contents survive a reset.
   logic [DW-1:0]    mem_q [pWords-1];
   logic [DW-1:0]    mailbox_q, mailbox_d;
   logic             wr_err_q, wr_err_d;

   logic             rd_legal, wr_legal, rd_accept, stall;
   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [DW-1:0]    rd_word;
   rsp_t             in_rsp;
   logic             pipe_out_valid;
   logic [DW:0]      pipe_out_bits;

   assign rd_legal = addr_legal(bus.iwRdAddr, pDataBytes, pWords);
   assign wr_legal = addr_legal(bus.iwWrAddr, pDataBytes, pWords);
   assign rd_idx   = bus.iwRdAddr[LOG2B +: IDX_W];
   assign wr_idx   = bus.iwWrAddr[LOG2B +: IDX_W];

   assign stall         = pipe_out_valid && !bus.iwRspReady;
   assign bus.owRdReady = !stall;
   assign rd_accept     = bus.iwRdValid && !stall;

   // Array read happens before this edge's write lands: read-first.
   assign rd_word = (rd_idx == LAST_IDX) ? mailbox_q : mem_q[rd_idx];

   always_comb begin
      in_rsp       = '0;
      in_rsp.valid = rd_accept;
      in_rsp.err   = !rd_legal;
      if (rd_legal) in_rsp.data[DW-1:0] = rd_word;
   end

   if (DW < MAX_DATA_W) begin : g_rsp_pad
      logic unused_rsp_pad;
      assign unused_rsp_pad = ^in_rsp.data[MAX_DATA_W-1:DW];
   end

   mem_rsp_pipe #(
      .DEPTH (pReadLatency),
      .W     (DW + 1)
   ) u_rsp_pipe (
      .iwClk     (iwClk),
      .iwnRst    (iwnRst),
      .in_valid  (in_rsp.valid),
      .in_bits   ({in_rsp.err, in_rsp.data[DW-1:0]}),
      .stall     (stall),
      .out_valid (pipe_out_valid),
      .out_bits  (pipe_out_bits)
   );

   assign bus.owRspValid = pipe_out_valid;
   assign bus.owRspErr   = pipe_out_bits[DW];
   assign bus.owRspData  = pipe_out_bits[DW-1:0];

   always_ff @(posedge iwClk) begin
      if (bus.iwWrValid && wr_legal && (wr_idx != LAST_IDX)) begin
         for (int i = 0; i < pDataBytes; i++) begin
            if (bus.iwWstrb[i]) mem_q[wr_idx][8*i +: 8] <= bus.iwWrData[8*i +: 8];
         end
      end
   end

   always_comb begin
      mailbox_d = mailbox_q;
      if (bus.iwWrValid && wr_legal && (wr_idx == LAST_IDX)) begin
         for (int i = 0; i < pDataBytes; i++) begin
            if (bus.iwWstrb[i]) mailbox_d[8*i +: 8] = bus.iwWrData[8*i +: 8];
         end
      end
   end

   always_comb begin
      wr_err_d = bus.iwWrValid && !wr_legal;
   end

   always_ff @(posedge iwClk or negedge iwnRst) begin
      if (!iwnRst) begin
         mailbox_q <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         mailbox_q <= mailbox_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign bus.owWrErr    = wr_err_q;
   assign bus.owLastData = mailbox_q;

endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory: directed table, hand-written corner sequences and a
// randomized phase against a word-array/queue reference model.
module tb_pipelined_memory;

   localparam int unsigned WORDS = 44;
   localparam int unsigned LAT   = 3;

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      bit          wv;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      bit          rv;
      logic [31:0] ra;
      logic        ee;
      logic [31:0] ed;
      logic        ewe;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipelined_memory_if #(.pDataBytes(4)) bus ();

   pipelined_memory #(
      .pWords       (WORDS),
      .pDataBytes   (4),
      .pReadLatency (LAT)
   ) dut (
      .iwClk  (clk),
      .iwnRst (rst_n),
      .bus    (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          rsp_count = 0;
   logic [31:0] ref_mem [WORDS];
   exp_t        q [$];
   bit          exp_wr_err = 1'b0;

   function automatic bit m_legal(input logic [31:0] a);
      return (a % 4 == 0) && (longint'(a) < longint'(WORDS * 4));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with inputs already driven; models the coming posedge.
   task automatic cycle(output bit acc);
      exp_t e;
      int   w;
      #1;
      chk("wr_err", bus.owWrErr, exp_wr_err);
      chk("last_data", bus.owLastData, ref_mem[WORDS-1]);
      chk("rd_ready", bus.owRdReady, !(bus.owRspValid && !bus.iwRspReady));
      if (bus.owRspValid && bus.iwRspReady) begin
         rsp_count++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rsp_spurious: got response data %h, want none", bus.owRspData);
         end else begin
            e = q.pop_front();
            chk("rsp_err", bus.owRspErr, e.err);
            chk("rsp_data", bus.owRspData, e.data);
         end
      end
      acc = bus.iwRdValid && bus.owRdReady;
      if (acc) begin
         if (m_legal(bus.iwRdAddr)) begin
            e.err  = 1'b0;
            e.data = ref_mem[bus.iwRdAddr / 4];
         end else begin
            e.err  = 1'b1;
            e.data = 32'h0;
         end
         q.push_back(e);
      end
      exp_wr_err = bus.iwWrValid && !m_legal(bus.iwWrAddr);
      if (bus.iwWrValid && m_legal(bus.iwWrAddr)) begin
         w = int'(bus.iwWrAddr / 4);
         for (int i = 0; i < 4; i++)
            if (bus.iwWstrb[i]) ref_mem[w][8*i +: 8] = bus.iwWrData[8*i +: 8];
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.iwRdValid  = 1'b0;
      bus.iwWrValid  = 1'b0;
      bus.iwWstrb    = 4'h0;
      bus.iwRspReady = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit acc;
      int n;
      bus.iwWrValid  = v.wv;
      bus.iwWrAddr   = v.wa;
      bus.iwWrData   = v.wd;
      bus.iwWstrb    = v.ws;
      bus.iwRdValid  = v.rv;
      bus.iwRdAddr   = v.ra;
      bus.iwRspReady = 1'b1;
      cycle(acc);
      idle_inputs();
      chk($sformatf("vec%0d_wr_err", idx), bus.owWrErr, v.ewe);
      if (v.rv) begin
         n = 0;
         while (!bus.owRspValid && n < 10) begin
            cycle(acc);
            n++;
         end
         chk($sformatf("vec%0d_rsp_valid", idx), bus.owRspValid, 1'b1);
         chk($sformatf("vec%0d_rsp_err", idx), bus.owRspErr, v.ee);
         chk($sformatf("vec%0d_rsp_data", idx), bus.owRspData, v.ed);
         cycle(acc);
      end
   endtask

   initial begin
      vec_t vecs[16];
      bit   acc;
      int   lat, k, stalled, base;

      vecs[0]  = '{1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0,  0, 32'h0,        0};
      vecs[1]  = '{1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0,  0, 32'h0,        0};
      vecs[2]  = '{0, 32'h0,  32'h0,        4'h0, 1, 32'h20, 0, 32'h11BB33DD, 0};
      vecs[3]  = '{0, 32'h0,  32'h0,        4'h0, 1, 32'h13, 1, 32'h0,        0};
      vecs[4]  = '{0, 32'h0,  32'h0,        4'h0, 1, 32'hB0, 1, 32'h0,        0};
      vecs[5]  = '{1, 32'hFFFFFFFC, 32'h12345678, 4'hF, 0, 32'h0, 0, 32'h0,   1};
      vecs[6]  = '{0, 32'h0,  32'h0,        4'h0, 1, 32'hFFFFFFFC, 1, 32'h0,  0};
      vecs[7]  = '{0, 32'h0,  32'h0,        4'h0, 1, 32'hFC, 0 | 1, 32'h0,    0};
      vecs[8]  = '{1, 32'h8,  32'h1,        4'hF, 0, 32'h0,  0, 32'h0,        0};
      vecs[9]  = '{1, 32'h8,  32'h5,        4'hF, 1, 32'h8,  0, 32'h1,        0};
      vecs[10] = '{0, 32'h0,  32'h0,        4'h0, 1, 32'h8,  0, 32'h5,        0};
      vecs[11] = '{1, 32'h30, 32'hFFFFFFFF, 4'h0, 0, 32'h0,  0, 32'h0,        0};
      vecs[12] = '{0, 32'h0,  32'h0,        4'h0, 1, 32'h30, 0, 32'hC0DE000C, 0};
      vecs[13] = '{0, 32'h0,  32'h0,        4'h0, 1, 32'h2,  1, 32'h0,        0};
      vecs[14] = '{1, 32'hAC, 32'h600D600D, 4'hF, 0, 32'h0,  0, 32'h0,        0};
      vecs[15] = '{0, 32'h0,  32'h0,        4'h0, 1, 32'h0,  0, 32'hC0DE0000, 0};

      rst_n = 1'b0;
      idle_inputs();
      bus.iwRdAddr = '0;
      bus.iwWrAddr = '0;
      bus.iwWrData = '0;
      ref_mem[WORDS-1] = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", bus.owRspValid, 1'b0);
      chk("rst_rsp_err", bus.owRspErr, 1'b0);
      chk("rst_rsp_data", bus.owRspData, 32'h0);
      chk("rst_wr_err", bus.owWrErr, 1'b0);
      chk("rst_last_data", bus.owLastData, 32'h0);
      chk("rst_rd_ready", bus.owRdReady, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill every word so later reads are defined.
      for (int w = 0; w < int'(WORDS); w++) begin
         bus.iwWrValid = 1'b1;
         bus.iwWrAddr  = 32'(w * 4);
         bus.iwWrData  = 32'hC0DE0000 | 32'(w);
         bus.iwWstrb   = 4'hF;
         cycle(acc);
      end
      idle_inputs();

      // Read latency of a legal access.
      bus.iwWrValid = 1'b1;
      bus.iwWrAddr  = 32'h10;
      bus.iwWrData  = 32'hDEADBEEF;
      bus.iwWstrb   = 4'hF;
      cycle(acc);
      idle_inputs();
      bus.iwRdValid = 1'b1;
      bus.iwRdAddr  = 32'h10;
      cycle(acc);
      idle_inputs();
      chk("lat_accept", acc, 1'b1);
      lat = 1;
      while (!bus.owRspValid && lat < 10) begin
         cycle(acc);
         lat++;
      end
      chk("lat_cycles", lat, LAT);
      chk("lat_data", bus.owRspData, 32'hDEADBEEF);
      chk("lat_err", bus.owRspErr, 1'b0);
      cycle(acc);

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);
      chk("mailbox_view", bus.owLastData, 32'h600D600D);

      // Backpressure with four back-to-back reads.
      base = rsp_count;
      k = 0;
      stalled = 0;
      bus.iwRspReady = 1'b0;
      for (int c = 0; c < 60 && !(k == 4 && q.size() == 0); c++) begin
         bus.iwRdValid = (k < 4);
         bus.iwRdAddr  = 32'(k * 4);
         if (stalled >= 5) bus.iwRspReady = 1'b1;
         cycle(acc);
         if (acc) k++;
         if (!bus.owRdReady) stalled++;
      end
      idle_inputs();
      chk("bp_issued", k, 4);
      chk("bp_stalled", stalled >= 5, 1'b1);
      chk("bp_rsp_count", rsp_count - base, 4);
      chk("bp_queue_empty", q.size(), 0);

      // Reset with two reads in flight.
      bus.iwRdValid = 1'b1;
      bus.iwRdAddr  = 32'h0;
      cycle(acc);
      bus.iwRdAddr  = 32'h4;
      cycle(acc);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_last_data", bus.owLastData, 32'h0);
      chk("mid_rst_rsp_valid", bus.owRspValid, 1'b0);
      chk("mid_rst_rsp_data", bus.owRspData, 32'h0);
      q.delete();
      ref_mem[WORDS-1] = 32'h0;
      exp_wr_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      base = rsp_count;
      for (int c = 0; c < 8; c++) cycle(acc);
      chk("post_rst_no_rsp", rsp_count - base, 0);
      run_vec(vecs[15], 99);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         bus.iwRdValid  = ($urandom_range(0, 99) < 50);
         bus.iwRdAddr   = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, WORDS - 1) * 4);
         bus.iwWrValid  = ($urandom_range(0, 99) < 30);
         bus.iwWrAddr   = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, WORDS - 1) * 4);
         bus.iwWrData   = $urandom();
         bus.iwWstrb    = 4'($urandom_range(0, 15));
         bus.iwRspReady = ($urandom_range(0, 99) < 70);
         cycle(acc);
      end
      idle_inputs();
      for (int c = 0; c < 20 && q.size() != 0; c++) cycle(acc);
      chk("drain_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
